// File: rtl/psc_pkg.sv
// Shared definitions for the setpoint-control path: ramp sequencer state
// encoding and the table/setpoint widths used by the register block and DAC serializer.
package psc_pkg;

  localparam int RAMP_ADDR_W = 13;
  localparam int STPT_DATA_W = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PLAY  = 2'd2
  } ramp_state_t;

endpackage

// File: rtl/ramp_table_ram.sv
// Ramp table storage: one write port, one read port, registered read data
// (1-cycle latency), no reset on the array so it maps onto block RAM.
module ramp_table_ram #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ramp_sequencer.sv
// Plays the preloaded setpoint ramp table to the DAC datapath, one sample per
// tick; table writes are accepted only while idle.
module ramp_sequencer
  import psc_pkg::*;
#(
  parameter int ADDR_W = RAMP_ADDR_W,
  parameter int DATA_W = STPT_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] ramp_len,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              run,
  input  logic              abort,
  input  logic              tick,
  output logic [DATA_W-1:0] dac_setpt,
  output logic              dac_valid,
  output logic              active,
  output logic              done,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              wr_reject
);

  ramp_state_t       state_q, state_d;
  logic              run_q;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] dac_setpt_q, dac_setpt_d;
  logic              dac_valid_q, dac_valid_d;
  logic              active_q, active_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              wr_reject_q, wr_reject_d;

  logic              run_edge;
  logic              issue;
  logic              ram_we;
  logic [DATA_W-1:0] rd_data;

  assign run_edge = run & ~run_q;
  assign ram_we   = wr_en && (state_q == IDLE);

  ramp_table_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_table (
    .clk     (clk),
    .we      (ram_we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .re      (issue),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    rd_ptr_d    = rd_ptr_q;
    inflight_d  = inflight_q;
    dac_setpt_d = dac_setpt_q;
    dac_valid_d = 1'b0;
    done_d      = 1'b0;
    cur_addr_d  = cur_addr_q;
    wr_reject_d = wr_en && (state_q != IDLE);
    issue       = 1'b0;

    case (state_q)
      IDLE: begin
        inflight_d = 1'b0;
        if (run_edge && !abort) begin
          len_d    = ramp_len;
          rd_ptr_d = '0;
          state_d  = ARMED;
        end
      end
      ARMED, PLAY: begin
        if (abort) begin
          state_d    = IDLE;
          inflight_d = 1'b0;
        end else if (done_q) begin
          // Stay active through the cycle that shows the final sample.
          state_d = IDLE;
        end else if (inflight_q) begin
          inflight_d  = 1'b0;
          dac_setpt_d = rd_data;
          dac_valid_d = 1'b1;
          cur_addr_d  = rd_ptr_q;
          if (rd_ptr_q == len_q) done_d = 1'b1;
          else                   rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end else if (tick) begin
          issue      = 1'b1;
          inflight_d = 1'b1;
          state_d    = PLAY;
        end
      end
      default: state_d = IDLE;
    endcase

    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      run_q       <= 1'b0;
      len_q       <= '0;
      rd_ptr_q    <= '0;
      inflight_q  <= 1'b0;
      dac_setpt_q <= '0;
      dac_valid_q <= 1'b0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
      cur_addr_q  <= '0;
      wr_reject_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run;
      len_q       <= len_d;
      rd_ptr_q    <= rd_ptr_d;
      inflight_q  <= inflight_d;
      dac_setpt_q <= dac_setpt_d;
      dac_valid_q <= dac_valid_d;
      active_q    <= active_d;
      done_q      <= done_d;
      cur_addr_q  <= cur_addr_d;
      wr_reject_q <= wr_reject_d;
    end
  end

  assign dac_setpt = dac_setpt_q;
  assign dac_valid = dac_valid_q;
  assign active    = active_q;
  assign done      = done_q;
  assign cur_addr  = cur_addr_q;
  assign wr_reject = wr_reject_q;

endmodule

// File: tb/tb_ramp_sequencer.sv
// Bench for ramp_sequencer: each issued tick pushes {due cycle, last, index, data}
// to exp_q; the negedge monitor pops one entry per dac_valid and compares.
module tb_ramp_sequencer;

  localparam int AW = 13;
  localparam int DW = 20;
  localparam int EW = 16 + 1 + AW + DW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] ramp_len = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_en = 1'b0;
  logic          run = 1'b0;
  logic          abort = 1'b0;
  logic          tick = 1'b0;
  logic [DW-1:0] dac_setpt;
  logic          dac_valid;
  logic          active;
  logic          done;
  logic [AW-1:0] cur_addr;
  logic          wr_reject;

  logic [DW-1:0] model [128];
  logic [EW-1:0] exp_q [$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int vcnt = 0;
  int vsave = 0;

  ramp_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ramp_len  (ramp_len),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .run       (run),
    .abort     (abort),
    .tick      (tick),
    .dac_setpt (dac_setpt),
    .dac_valid (dac_valid),
    .active    (active),
    .done      (done),
    .cur_addr  (cur_addr),
    .wr_reject (wr_reject)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic write(input int a, input logic [DW-1:0] d);
    wr_addr = AW'(a);
    wr_data = d;
    wr_en   = 1'b1;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic start(input int len, input bit with_tick);
    ramp_len = AW'(len);
    run      = 1'b1;
    tick     = with_tick;
    step();
    run      = 1'b0;
    tick     = 1'b0;
  endtask

  task automatic tick_exp(input int a, input bit last);
    tick = 1'b1;
    exp_q.push_back({16'(cyc + 2), last, AW'(a), model[a]});
    step();
    tick = 1'b0;
  endtask

  task automatic tick_none();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic play(input int first, input int last, input int len);
    for (int i = first; i <= last; i++) begin
      tick_exp(i, i == len);
      idle(9);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    chk("drain", 64'(exp_q.size()), 0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset_n) begin
      if (dac_valid) begin
        logic [EW-1:0] e;
        vcnt++;
        chk("valid_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("setpt", 64'(dac_setpt), 64'(e[DW-1:0]));
          chk("cur_addr", 64'(cur_addr), 64'(e[DW +: AW]));
          chk("done_flag", 64'(done), 64'(e[DW+AW]));
          chk("latency", 64'(cyc[15:0]), 64'(e[EW-1 -: 16]));
        end
      end else if (done) begin
        chk("done_without_valid", 64'(done), 0);
      end
    end
  end

  initial begin
    // reset state
    #3;
    chk("rst_setpt", 64'(dac_setpt), 0);
    chk("rst_valid", 64'(dac_valid), 0);
    chk("rst_active", 64'(active), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_cur_addr", 64'(cur_addr), 0);
    chk("rst_wr_reject", 64'(wr_reject), 0);
    idle(2);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 128; i++) model[i] = DW'(i);
    for (int i = 0; i <= 100; i++) write(i, DW'(i));

    // basic run 0..100
    start(100, 1'b0);
    chk("run_active", 64'(active), 1);
    idle(3);
    vsave = vcnt;
    play(0, 99, 100);
    tick_exp(100, 1'b1);
    step();
    chk("last_active_t2", 64'(active), 1);
    chk("last_done_t2", 64'(done), 1);
    step();
    chk("last_active_t3", 64'(active), 0);
    drain();
    chk("basic_count", 64'(vcnt - vsave), 101);
    idle(3);
    chk("basic_hold", 64'(dac_setpt), 100);

    // single sample, tick coincident with run edge not consumed
    write(0, 20'hFFFFF);
    model[0] = 20'hFFFFF;
    start(0, 1'b1);
    idle(3);
    tick_exp(0, 1'b1);
    drain();
    idle(2);
    chk("single_setpt", 64'(dac_setpt), 64'(20'hFFFFF));
    chk("single_active", 64'(active), 0);
    write(0, '0);
    model[0] = '0;

    // abort while index 50 is in flight
    start(100, 1'b0);
    play(0, 49, 100);
    tick_none();
    chk("abort_pre_active", 64'(active), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_active", 64'(active), 0);
    idle(5);
    chk("abort_hold_setpt", 64'(dac_setpt), 49);
    chk("abort_hold_addr", 64'(cur_addr), 49);
    start(3, 1'b0);
    play(0, 3, 3);
    drain();

    // write lockout during playback
    write(120, 20'h7);
    model[120] = 20'h7;
    chk("idle_wr_reject", 64'(wr_reject), 0);
    start(10, 1'b0);
    play(0, 2, 10);
    write(5, 20'h12345);
    chk("lock_wr_reject", 64'(wr_reject), 1);
    step();
    chk("lock_wr_reject_end", 64'(wr_reject), 0);
    play(3, 10, 10);
    drain();
    start(5, 1'b0);
    play(0, 5, 5);
    drain();

    // run edge while active, ramp_len change mid-run
    start(5, 1'b0);
    play(0, 1, 5);
    ramp_len = AW'(2);
    run = 1'b1;
    step();
    run = 1'b0;
    play(2, 5, 5);
    drain();
    idle(2);
    chk("rerun_ignored_active", 64'(active), 0);

    // run edge and abort together in IDLE
    vsave = vcnt;
    ramp_len = AW'(3);
    run = 1'b1;
    abort = 1'b1;
    step();
    run = 1'b0;
    abort = 1'b0;
    step();
    chk("run_abort_active", 64'(active), 0);
    tick_none();
    idle(5);
    chk("run_abort_no_valid", 64'(vcnt - vsave), 0);

    // asynchronous reset mid-run
    start(100, 1'b0);
    play(0, 9, 100);
    tick_none();
    #1;
    reset_n = 1'b0;
    #2;
    chk("mid_rst_setpt", 64'(dac_setpt), 0);
    chk("mid_rst_active", 64'(active), 0);
    chk("mid_rst_cur_addr", 64'(cur_addr), 0);
    chk("mid_rst_valid", 64'(dac_valid), 0);
    chk("mid_rst_done", 64'(done), 0);
    idle(2);
    reset_n = 1'b1;
    step();
    chk("post_rst_active", 64'(active), 0);
    vsave = vcnt;
    tick_none();
    idle(4);
    chk("post_rst_idle", 64'(vcnt - vsave), 0);
    start(10, 1'b0);
    play(0, 10, 10);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
